// File: rtl/fft_stream_pkg.sv
// rtl/fft_stream_pkg.sv - default sizing and stream FSM state type for the FFT frame feeder
package fft_stream_pkg;

  localparam int FFT_WIDTH = 16;
  localparam int FFT_N     = 1024;
  localparam int FFT_GAP   = 513;
  localparam int FRAME_CYC = FFT_N / 2;
  localparam int ADDR_W    = $clog2(FFT_N / 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM
  } stream_state_e;

endpackage

// File: rtl/fft_pingpong_ram.sv
// rtl/fft_pingpong_ram.sv - two-bank sample-pair RAM, one write port, one registered read port
module fft_pingpong_ram
  import fft_stream_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int AW    = ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW:0]        wr_addr,
  input  logic [2*WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW:0]        rd_addr,
  output logic [2*WIDTH-1:0] rd_data
);

  logic [2*WIDTH-1:0] mem [0:(2**(AW+1))-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register returns zero when no read is issued, so it can drive the outputs directly.
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - packs real samples into ping-pong frames and streams them to dft_top
module fft_frame_feeder
  import fft_stream_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int N     = FFT_N,
  parameter int GAP   = FFT_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             next,
  output logic [WIDTH-1:0] X0,
  output logic [WIDTH-1:0] X1,
  output logic [WIDTH-1:0] X2,
  output logic [WIDTH-1:0] X3,
  output logic             busy
);

  localparam int HALF = N / 2;
  localparam int AW   = $clog2(HALF);
  localparam int WPW  = $clog2(N);
  localparam int GW   = $clog2(GAP);
  localparam logic [GW-1:0]  GAP_SAT  = GW'(GAP - 1);
  localparam logic [WPW-1:0] WP_LAST  = WPW'(N - 1);
  localparam logic [AW-1:0]  CNT_LAST = AW'(HALF - 1);

  stream_state_e state_q, state_n;

  logic [1:0]         full_q, full_n;
  logic               fill_bank_q, read_bank_q;
  logic [WPW-1:0]     wp_q;
  logic [WIDTH-1:0]   pair_q;
  logic [GW-1:0]      gap_q;
  logic [AW-1:0]      cnt_q;
  logic               next_q, busy_q;
  logic               hs, fill_done, release_bank, gap_ok;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [2*WIDTH-1:0] rd_data;

  assign sample_ready = ~full_q[fill_bank_q];
  assign hs           = sample_valid & sample_ready;
  assign fill_done    = hs && (wp_q == WP_LAST);
  assign gap_ok       = (gap_q >= GAP_SAT);

  always_comb begin
    state_n      = state_q;
    release_bank = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[read_bank_q] && gap_ok) state_n = ST_START;
      end
      ST_START: begin
        rd_en   = 1'b1;
        state_n = ST_STREAM;
      end
      ST_STREAM: begin
        rd_addr = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          release_bank = 1'b1;
          // Chain straight into the next frame so back-to-back frames keep the minimum spacing.
          state_n = (full_q[~read_bank_q] && gap_ok) ? ST_START : ST_IDLE;
        end else begin
          rd_en = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    full_n = full_q;
    if (release_bank) full_n[read_bank_q] = 1'b0;
    if (fill_done)    full_n[fill_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      full_q      <= '0;
      fill_bank_q <= 1'b0;
      read_bank_q <= 1'b0;
      wp_q        <= '0;
      pair_q      <= '0;
      gap_q       <= GAP_SAT;
      cnt_q       <= '0;
      next_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_n;
      full_q  <= full_n;
      next_q  <= (state_n == ST_START);
      busy_q  <= (state_n != ST_IDLE);
      cnt_q   <= (state_q == ST_STREAM) ? cnt_q + 1'b1 : '0;
      if (state_n == ST_START)  gap_q <= '0;
      else if (gap_q != GAP_SAT) gap_q <= gap_q + 1'b1;
      if (release_bank) read_bank_q <= ~read_bank_q;
      if (hs) begin
        wp_q <= wp_q + 1'b1;
        if (!wp_q[0]) pair_q <= sample_in;
        if (fill_done) fill_bank_q <= ~fill_bank_q;
      end
    end
  end

  fft_pingpong_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (hs & wp_q[0]),
    .wr_addr ({fill_bank_q, wp_q[WPW-1:1]}),
    .wr_data ({sample_in, pair_q}),
    .rd_en   (rd_en),
    .rd_addr ({read_bank_q, rd_addr}),
    .rd_data (rd_data)
  );

  assign next = next_q;
  assign busy = busy_q;
  assign X0   = rd_data[WIDTH-1:0];
  assign X2   = rd_data[2*WIDTH-1:WIDTH];
  assign X1   = '0;
  assign X3   = '0;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - directed bench for fft_frame_feeder (default core plus a small-gap core)
module tb_fft_frame_feeder;

  localparam int HALF = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, next, busy;
  logic [15:0] X0, X1, X2, X3;

  logic        g_reset = 1'b1;
  logic [15:0] g_in = '0;
  logic        g_valid = 1'b0;
  logic        g_ready, g_next, g_busy;
  logic [15:0] g_X0, g_X1, g_X2, g_X3;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_hs = 0;
  int str_left = 0;
  int streamed = 0;
  bit mon_en = 1'b0;
  logic [15:0] exp_q[$];
  int next_hist[$];
  logic [15:0] e0, e1;

  fft_frame_feeder dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .next(next), .X0(X0), .X1(X1), .X2(X2), .X3(X3), .busy(busy)
  );

  fft_frame_feeder #(.WIDTH(16), .N(16), .GAP(40)) dut_gap (
    .clk(clk), .reset(g_reset), .sample_in(g_in), .sample_valid(g_valid),
    .sample_ready(g_ready), .next(g_next), .X0(g_X0), .X1(g_X1), .X2(g_X2), .X3(g_X3), .busy(g_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every streamed pair must be the next two accepted samples, in order.
  always @(negedge clk) begin
    if (!mon_en) begin
      str_left = 0;
    end else if (str_left > 0) begin
      if (exp_q.size() < 2) begin
        check("stream_underflow", exp_q.size(), 2);
        str_left = 0;
      end else begin
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        check("X0", X0, e0);
        check("X2", X2, e1);
        check("X1X3", {X1, X3}, 0);
        check("busy_stream", busy, 1);
        check("next_stream", next, 0);
        streamed += 2;
        str_left--;
      end
    end else if (next) begin
      next_hist.push_back(cyc);
      check("busy_start", busy, 1);
      check("X_start", {X0, X2}, 0);
      str_left = HALF;
    end else begin
      check("busy_idle", busy, 0);
      check("X_idle", {X0, X2}, 0);
    end
  end

  // mode: 0 full rate, 1 every 3rd cycle, 2 random. kind: 0 i%32, 1 8000/7FFF, 2 base+i, 3 random.
  task automatic feed(input int count, input int mode, input int kind, input int base);
    int i = 0;
    int slot = 0;
    logic v;
    logic [15:0] val;
    logic [15:0] rv = 16'($urandom);
    while (i < count && slot < count * 8 + 100) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (slot % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      case (kind)
        0:       val = 16'(i % 32);
        1:       val = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
        2:       val = 16'(base + i);
        default: val = rv;
      endcase
      sample_valid = v;
      sample_in = val;
      if (v && sample_ready) begin
        exp_q.push_back(val);
        last_hs = cyc;
        i++;
        rv = 16'($urandom);
      end
      slot++;
    end
    if (i != count) check("feed_timeout", i, count);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_next(input string tag);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!next && t < 3000);
    check(tag, cyc - last_hs, 2);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || str_left != 0) && t < 8000) begin
      @(negedge clk);
      t++;
    end
    check(tag, exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int n0, blen, gnext, gi, s;

    repeat (3) @(negedge clk);
    check("rst_next", next, 0);
    check("rst_X0", X0, 0);
    check("rst_X1", X1, 0);
    check("rst_X2", X2, 0);
    check("rst_X3", X3, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", sample_ready, 1);
    reset = 1'b0;
    mon_en = 1'b1;

    // 1: one frame of i%32 at full rate
    feed(1024, 0, 0, 0);
    wait_next("t1_next_lat");
    blen = 0;
    while (busy && blen < 600) begin
      blen++;
      @(negedge clk);
    end
    check("t1_busy_len", blen, 513);
    wait_drain("t1_drain");

    // 2: small core (N=16, GAP=40) fed continuously, so both banks fill and next is gap-limited
    @(negedge clk);
    g_reset = 1'b0;
    g_valid = 1'b1;
    gi = 0;
    g_in = 16'd100;
    gnext = 0;
    for (int t = 0; t < 100; t++) begin
      if (g_next) gnext++;
      if (t == 17 || t == 57 || t == 97) check($sformatf("t2_next_%0d", t), g_next, 1);
      if (t == 17) check("t2_X0_start", g_X0, 0);
      if (t == 18) check("t2_X0_f0", g_X0, 100);
      if (t == 18) check("t2_X2_f0", g_X2, 101);
      if (t == 47) check("t2_ready_47", g_ready, 1);
      if (t == 48) check("t2_ready_both_full", g_ready, 0);
      if (t == 58) check("t2_X0_f1", g_X0, 116);
      if (t == 58) check("t2_X2_f1", g_X2, 117);
      if (t == 65) check("t2_X0_f1_last", g_X0, 130);
      if (t == 65) check("t2_X2_f1_last", g_X2, 131);
      if (t == 65) check("t2_ready_65", g_ready, 0);
      if (t == 66) check("t2_ready_66", g_ready, 1);
      if (t == 66) check("t2_busy_66", g_busy, 0);
      if (g_ready) gi++;
      @(negedge clk);
      g_in = 16'(100 + gi);
    end
    g_valid = 1'b0;
    check("t2_next_count", gnext, 3);

    // 3: valid every third cycle
    n0 = next_hist.size();
    feed(1024, 1, 2, 300);
    check("t3_no_early_next", next_hist.size(), n0);
    wait_next("t3_next_lat");
    wait_drain("t3_drain");

    // 4: reset at STREAM cycle 200, with a partial frame also in flight
    feed(1024, 0, 2, 1000);
    wait_next("t4_next_lat");
    s = cyc;
    feed(150, 0, 2, 5000);
    while (cyc < s + 200) @(negedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    check("t4_next", next, 0);
    check("t4_X0", X0, 0);
    check("t4_X2", X2, 0);
    check("t4_X1X3", {X1, X3}, 0);
    check("t4_busy", busy, 0);
    check("t4_ready", sample_ready, 1);
    reset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    feed(1024, 0, 2, 0);
    wait_next("t4_post_next_lat");
    wait_drain("t4_drain");

    // 5: extreme values pass bit-exact
    feed(1024, 0, 1, 0);
    wait_next("t5_next_lat");
    wait_drain("t5_drain");

    // 6: random valid, random data, three frames
    n0 = next_hist.size();
    streamed = 0;
    feed(3072, 2, 3, 0);
    wait_drain("t6_drain");
    check("t6_streamed", streamed, 3072);
    check("t6_frames", next_hist.size() - n0, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
